// File: rtl/miller_tx_scheduler_if.sv
// Byte-stream requesters, encoder bit link and status of the Miller TX scheduler.
`timescale 1ns/1ps
interface miller_tx_scheduler_if;
   logic [7:0] s0_tdata;
   logic       s0_tvalid;
   logic       s0_tlast;
   logic       s0_tready;
   logic [7:0] s1_tdata;
   logic       s1_tvalid;
   logic       s1_tlast;
   logic       s1_tready;
   logic       enc_bit;
   logic       enc_bit_valid;
   logic       enc_bit_tready;
   logic [1:0] grant;
   logic       busy;
   logic       frame_done;
   logic       err_underrun;
   logic       err_timeout;

   // Scheduler side
   modport slave (
      input  s0_tdata, s0_tvalid, s0_tlast, s1_tdata, s1_tvalid, s1_tlast, enc_bit_tready,
      output s0_tready, s1_tready, enc_bit, enc_bit_valid, grant, busy, frame_done,
             err_underrun, err_timeout
   );

   // Requester / encoder side
   modport master (
      output s0_tdata, s0_tvalid, s0_tlast, s1_tdata, s1_tvalid, s1_tlast, enc_bit_tready,
      input  s0_tready, s1_tready, enc_bit, enc_bit_valid, grant, busy, frame_done,
             err_underrun, err_timeout
   );
endinterface

// File: rtl/miller_tx_scheduler.sv
// Frame scheduler for the Miller line encoder: round-robin per frame between two byte
// sources, preamble insertion, MSB-first serialisation paced by the encoder's tready pulse,
// inter-frame gap, and recovery from source underrun or encoder stall.
`timescale 1ns/1ps
module miller_tx_scheduler #(
   parameter int unsigned PREAMBLE_LEN   = 8,
   parameter logic [15:0] PREAMBLE       = 16'h00AA,
   parameter int unsigned IFG_CYCLES     = 64,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input logic                  clk,
   input logic                  rst_n,
   miller_tx_scheduler_if.slave bus
);
   localparam int unsigned TmoW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned GapW    = $clog2(IFG_CYCLES + 1);
   localparam logic [3:0]  PreLast = 4'(PREAMBLE_LEN - 1);

   typedef enum logic [2:0] {StIdle, StPre, StData, StFlush, StGap} state_e;

   state_e          state_q, state_d;
   logic [1:0]      grant_q, grant_d;
   logic            last_s1_q, last_s1_d;     // requester served by the previous frame
   logic [7:0]      buf_q, buf_d;
   logic            buf_full_q, buf_full_d;
   logic            buf_last_q, buf_last_d;
   logic            last_acc_q, last_acc_d;   // tlast of this frame already taken
   logic [7:0]      shift_q, shift_d;
   logic            shift_last_q, shift_last_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [3:0]      pre_idx_q, pre_idx_d;
   logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
   logic            frame_done_q, frame_done_d;
   logic            err_underrun_q, err_underrun_d;
   logic            err_timeout_q, err_timeout_d;

   logic [7:0]      sel_tdata, next_byte;
   logic            sel_tvalid, sel_tlast, sel_tready, accept;
   logic            active, byte_avail, next_last, tmo_hit;
   logic [3:0]      pre_bit_idx;

   // Source mux, handshake and status decode for the granted requester
   always_comb begin
      sel_tdata   = grant_q[1] ? bus.s1_tdata  : bus.s0_tdata;
      sel_tvalid  = grant_q[1] ? bus.s1_tvalid : bus.s0_tvalid;
      sel_tlast   = grant_q[1] ? bus.s1_tlast  : bus.s0_tlast;
      active      = (state_q == StPre) || (state_q == StData);
      sel_tready  = (active && !buf_full_q && !last_acc_q) || (state_q == StFlush);
      accept      = sel_tready && sel_tvalid;
      // A byte accepted in the same cycle as the load decision is forwarded directly
      byte_avail  = buf_full_q || accept;
      next_byte   = buf_full_q ? buf_q : sel_tdata;
      next_last   = buf_full_q ? buf_last_q : sel_tlast;
      tmo_hit     = active && !bus.enc_bit_tready &&
                    (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));
      pre_bit_idx = PreLast - pre_idx_q;
   end

   assign bus.s0_tready     = grant_q[0] && sel_tready;
   assign bus.s1_tready     = grant_q[1] && sel_tready;
   assign bus.enc_bit       = (state_q == StPre)  ? PREAMBLE[pre_bit_idx] :
                              (state_q == StData) ? shift_q[7] : 1'b0;
   assign bus.enc_bit_valid = active;
   assign bus.grant         = grant_q;
   assign bus.busy          = (state_q != StIdle);
   assign bus.frame_done    = frame_done_q;
   assign bus.err_underrun  = err_underrun_q;
   assign bus.err_timeout   = err_timeout_q;

   // Next-state: arbitration, byte prefetch, bit pacing, error recovery, gap timing
   always_comb begin
      state_d        = state_q;
      grant_d        = grant_q;
      last_s1_d      = last_s1_q;
      buf_d          = buf_q;
      buf_full_d     = buf_full_q;
      buf_last_d     = buf_last_q;
      last_acc_d     = last_acc_q;
      shift_d        = shift_q;
      shift_last_d   = shift_last_q;
      bit_cnt_d      = bit_cnt_q;
      pre_idx_d      = pre_idx_q;
      tmo_cnt_d      = '0;
      gap_cnt_d      = '0;
      frame_done_d   = 1'b0;
      err_underrun_d = 1'b0;
      err_timeout_d  = 1'b0;

      if (active && accept) begin
         buf_d      = sel_tdata;
         buf_full_d = 1'b1;
         buf_last_d = sel_tlast;
         last_acc_d = sel_tlast;
      end
      if (active && !bus.enc_bit_tready) tmo_cnt_d = tmo_cnt_q + TmoW'(1);

      unique case (state_q)
         StIdle: begin
            if (bus.s0_tvalid || bus.s1_tvalid) begin
               grant_d      = (bus.s1_tvalid && (!bus.s0_tvalid || !last_s1_q)) ? 2'b10 : 2'b01;
               state_d      = StPre;
               pre_idx_d    = '0;
               bit_cnt_d    = '0;
               buf_full_d   = 1'b0;
               buf_last_d   = 1'b0;
               last_acc_d   = 1'b0;
               shift_last_d = 1'b0;
            end
         end
         StPre: begin
            if (bus.enc_bit_tready) begin
               if (pre_idx_q == PreLast) begin
                  if (byte_avail) begin
                     shift_d      = next_byte;
                     shift_last_d = next_last;
                     buf_full_d   = 1'b0;
                     bit_cnt_d    = '0;
                     state_d      = StData;
                  end else begin
                     err_underrun_d = 1'b1;
                     state_d        = last_acc_q ? StGap : StFlush;
                  end
               end else begin
                  pre_idx_d = pre_idx_q + 4'd1;
               end
            end else if (tmo_hit) begin
               err_timeout_d = 1'b1;
               buf_full_d    = 1'b0;
               state_d       = last_acc_d ? StGap : StFlush;
            end
         end
         StData: begin
            if (bus.enc_bit_tready) begin
               if (bit_cnt_q == 3'd7) begin
                  if (shift_last_q) begin
                     frame_done_d = 1'b1;
                     state_d      = StGap;
                  end else if (byte_avail) begin
                     shift_d      = next_byte;
                     shift_last_d = next_last;
                     buf_full_d   = 1'b0;
                     bit_cnt_d    = '0;
                  end else begin
                     err_underrun_d = 1'b1;
                     state_d        = last_acc_q ? StGap : StFlush;
                  end
               end else begin
                  shift_d   = {shift_q[6:0], 1'b0};
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end else if (tmo_hit) begin
               err_timeout_d = 1'b1;
               buf_full_d    = 1'b0;
               state_d       = last_acc_d ? StGap : StFlush;
            end
         end
         StFlush: begin
            if (accept && sel_tlast) state_d = StGap;
         end
         StGap: begin
            if (gap_cnt_q == GapW'(IFG_CYCLES - 1)) begin
               state_d   = StIdle;
               grant_d   = 2'b00;
               last_s1_d = grant_q[1];
            end else begin
               gap_cnt_d = gap_cnt_q + GapW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers; reset aborts any frame in progress
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= StIdle;
         grant_q        <= 2'b00;
         last_s1_q      <= 1'b1;
         buf_q          <= '0;
         buf_full_q     <= 1'b0;
         buf_last_q     <= 1'b0;
         last_acc_q     <= 1'b0;
         shift_q        <= '0;
         shift_last_q   <= 1'b0;
         bit_cnt_q      <= '0;
         pre_idx_q      <= '0;
         tmo_cnt_q      <= '0;
         gap_cnt_q      <= '0;
         frame_done_q   <= 1'b0;
         err_underrun_q <= 1'b0;
         err_timeout_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         grant_q        <= grant_d;
         last_s1_q      <= last_s1_d;
         buf_q          <= buf_d;
         buf_full_q     <= buf_full_d;
         buf_last_q     <= buf_last_d;
         last_acc_q     <= last_acc_d;
         shift_q        <= shift_d;
         shift_last_q   <= shift_last_d;
         bit_cnt_q      <= bit_cnt_d;
         pre_idx_q      <= pre_idx_d;
         tmo_cnt_q      <= tmo_cnt_d;
         gap_cnt_q      <= gap_cnt_d;
         frame_done_q   <= frame_done_d;
         err_underrun_q <= err_underrun_d;
         err_timeout_q  <= err_timeout_d;
      end
   end
endmodule

// File: tb/tb_miller_tx_scheduler.sv
// Self-checking bench for miller_tx_scheduler: random byte sources, a 16-clk/bit encoder
// model, a per-frame line monitor and a frame-level reference model.
`timescale 1ns/1ps
module tb_miller_tx_scheduler;
   localparam int unsigned PreLen  = 8;
   localparam logic [15:0] PreBits = 16'h00AA;
   localparam int unsigned Ifg     = 64;
   localparam int unsigned Tmo     = 64;

   typedef struct { logic [7:0] d; logic last; int dly; } item_t;
   typedef struct {
      logic [1:0] gnt; bit gnt_chg; int nbits; logic [63:0] bits;
      int ndone; int nund; int ntmo; int nacc;
      int last_rdy; int vfall; int bfall; int done_cyc; int und_cyc; int tmo_cyc;
   } frame_t;

   logic   clk = 1'b0;
   logic   rst_n = 1'b1;
   int     cyc = 0;
   int     n_checks = 0;
   int     n_fail = 0;
   int     hs_expired = 0;
   int     stall_after = -1;
   bit     drv_abort = 1'b0;
   item_t  s0_q[$];
   item_t  s1_q[$];
   frame_t frames[$];

   miller_tx_scheduler_if bus ();

   miller_tx_scheduler #(
      .PREAMBLE_LEN   (PreLen),
      .PREAMBLE       (PreBits),
      .IFG_CYCLES     (Ifg),
      .TIMEOUT_CYCLES (Tmo)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference line content: preamble bits MSB-first followed by payload bytes MSB-first
   function automatic logic [63:0] line_model(input int nbytes, input logic [63:0] payload);
      logic [63:0] v = '0;
      for (int i = PreLen - 1; i >= 0; i--) v = (v << 1) | 64'(PreBits[i]);
      return (v << (8 * nbytes)) | payload;
   endfunction

   task automatic set_src(input int src, input logic [7:0] d, input logic last, input logic v);
      if (src == 0) begin
         bus.s0_tdata = d; bus.s0_tlast = last; bus.s0_tvalid = v;
      end else begin
         bus.s1_tdata = d; bus.s1_tlast = last; bus.s1_tvalid = v;
      end
   endtask

   task automatic drive_item(input int src, input item_t it);
      int budget = 4000;
      repeat (it.dly) @(posedge clk);
      #1 set_src(src, it.d, it.last, 1'b1);
      forever begin
         @(negedge clk);
         if (drv_abort) break;
         if ((src == 0) ? bus.s0_tready : bus.s1_tready) begin
            @(posedge clk);
            break;
         end
         budget--;
         if (budget == 0) begin
            hs_expired++;
            break;
         end
      end
      #1 set_src(src, 8'h00, 1'b0, 1'b0);
   endtask

   initial begin : src0_drv
      item_t it;
      set_src(0, 8'h00, 1'b0, 1'b0);
      forever begin
         @(posedge clk);
         if (drv_abort) s0_q.delete();
         else if (s0_q.size() > 0) begin
            it = s0_q.pop_front();
            drive_item(0, it);
         end
      end
   end

   initial begin : src1_drv
      item_t it;
      set_src(1, 8'h00, 1'b0, 1'b0);
      forever begin
         @(posedge clk);
         if (drv_abort) s1_q.delete();
         else if (s1_q.size() > 0) begin
            it = s1_q.pop_front();
            drive_item(1, it);
         end
      end
   end

   // Encoder: one-cycle tready every 16 clk while enabled, optionally stalling after N bits
   initial begin : enc_model
      int phase = 0;
      int taken = 0;
      bus.enc_bit_tready = 1'b0;
      forever begin
         @(posedge clk);
         #1 bus.enc_bit_tready = 1'b0;
         if (rst_n && bus.enc_bit_valid) begin
            phase++;
            if (phase >= 16 && (stall_after < 0 || taken < stall_after)) begin
               bus.enc_bit_tready = 1'b1;
               phase = 0;
               taken++;
            end
         end else begin
            phase = 0;
            taken = 0;
         end
      end
   end

   // Per-frame monitor, frame closes when busy falls
   initial begin : monitor
      frame_t cur;
      bit in_frame = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            in_frame = 1'b0;
         end else begin
            if (!in_frame && bus.busy) begin
               in_frame = 1'b1;
               cur = '{gnt: bus.grant, gnt_chg: 1'b0, nbits: 0, bits: '0, ndone: 0, nund: 0,
                       ntmo: 0, nacc: 0, last_rdy: -1, vfall: -1, bfall: -1, done_cyc: -1,
                       und_cyc: -1, tmo_cyc: -1};
            end
            if (in_frame) begin
               if (bus.busy && bus.grant != cur.gnt) cur.gnt_chg = 1'b1;
               if (bus.enc_bit_valid && bus.enc_bit_tready) begin
                  cur.bits = {cur.bits[62:0], bus.enc_bit};
                  cur.nbits++;
                  cur.last_rdy = cyc;
               end
               if (!bus.enc_bit_valid && cur.vfall < 0) cur.vfall = cyc;
               if (bus.frame_done) begin cur.ndone++; cur.done_cyc = cyc; end
               if (bus.err_underrun) begin cur.nund++; cur.und_cyc = cyc; end
               if (bus.err_timeout) begin cur.ntmo++; cur.tmo_cyc = cyc; end
               if ((bus.s0_tvalid && bus.s0_tready) || (bus.s1_tvalid && bus.s1_tready))
                  cur.nacc++;
               if (!bus.busy) begin
                  cur.bfall = cyc;
                  frames.push_back(cur);
                  in_frame = 1'b0;
               end
            end
         end
      end
   end

   task automatic check_reset(input string tag);
      check_val({tag, "_grant"}, 64'(bus.grant), 64'd0);
      check_val({tag, "_busy_valid_bit"}, 64'({bus.busy, bus.enc_bit_valid, bus.enc_bit}), 64'd0);
      check_val({tag, "_treadys"}, 64'({bus.s0_tready, bus.s1_tready}), 64'd0);
      check_val({tag, "_pulses"}, 64'({bus.frame_done, bus.err_underrun, bus.err_timeout}), 64'd0);
   endtask

   task automatic apply_reset();
      drv_abort = 1'b1;
      #2 rst_n = 1'b0;
      #1 check_reset("reset");
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b1;
      drv_abort = 1'b0;
      frames.delete();
      @(posedge clk);
   endtask

   task automatic wait_frames(input int n, input int budget);
      int left = budget;
      while (frames.size() < n && left > 0) begin
         @(negedge clk);
         left--;
      end
      check_val("frame_count", 64'(frames.size()), 64'(n));
   endtask

   task automatic check_frame(input string tag, input frame_t f, input logic [1:0] gnt,
                              input int nbits, input logic [63:0] bits, input int ndone,
                              input int nund, input int ntmo);
      check_val({tag, "_grant"}, 64'(f.gnt), 64'(gnt));
      check_val({tag, "_grant_stable"}, 64'(f.gnt_chg), 64'd0);
      check_val({tag, "_nbits"}, 64'(f.nbits), 64'(nbits));
      check_val({tag, "_bits"}, f.bits, bits);
      check_val({tag, "_frame_done"}, 64'(f.ndone), 64'(ndone));
      check_val({tag, "_underrun"}, 64'(f.nund), 64'(nund));
      check_val({tag, "_timeout"}, 64'(f.ntmo), 64'(ntmo));
   endtask

   // Queue a random frame on a source; returns its payload for the model
   task automatic build_frame(input int src, input int nbytes, input int maxdly,
                              output logic [63:0] payload);
      item_t it;
      payload = '0;
      for (int i = 0; i < nbytes; i++) begin
         it.d    = 8'($urandom);
         it.last = (i == nbytes - 1);
         it.dly  = int'($urandom_range(0, maxdly));
         payload = (payload << 8) | 64'(it.d);
         if (src == 0) s0_q.push_back(it);
         else          s1_q.push_back(it);
      end
   endtask

   initial begin : main
      int          nb[2][3];
      logic [63:0] pl[2][3];
      logic [63:0] p;
      logic [7:0]  b1;
      int          n;
      frame_t      f;

      #3 rst_n = 1'b0;
      #1 check_reset("reset_init");
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);

      // Single s0 frame {A5, last}
      s0_q.push_back('{d: 8'hA5, last: 1'b1, dly: 0});
      wait_frames(1, 2000);
      if (frames.size() >= 1) begin
         f = frames[0];
         check_frame("single", f, 2'b01, PreLen + 8, line_model(1, 64'hA5), 1, 0, 0);
         check_val("single_valid_drop", 64'(f.vfall - f.last_rdy), 64'd1);
         check_val("single_done_cycle", 64'(f.done_cyc), 64'(f.vfall));
         check_val("single_gap_len", 64'(f.bfall - f.vfall), 64'(Ifg));
         check_val("single_nacc", 64'(f.nacc), 64'd1);
      end

      // Both sources continuously requesting after reset: strict alternation from s0
      apply_reset();
      for (int k = 0; k < 3; k++) begin
         for (int s = 0; s < 2; s++) begin
            nb[s][k] = int'($urandom_range(1, 4));
            build_frame(s, nb[s][k], 3, pl[s][k]);
         end
      end
      wait_frames(6, 12000);
      for (int k = 0; k < 6 && k < frames.size(); k++) begin
         check_frame($sformatf("rr%0d", k), frames[k], (k % 2 == 0) ? 2'b01 : 2'b10,
                     PreLen + 8 * nb[k % 2][k / 2], line_model(nb[k % 2][k / 2], pl[k % 2][k / 2]),
                     1, 0, 0);
      end

      // s1 three-byte frame, bytes offered late but inside the bit budget
      frames.delete();
      s1_q.push_back('{d: 8'h00, last: 1'b0, dly: 0});
      s1_q.push_back('{d: 8'hFF, last: 1'b0, dly: int'($urandom_range(0, 10))});
      s1_q.push_back('{d: 8'h3C, last: 1'b1, dly: int'($urandom_range(0, 10))});
      wait_frames(1, 3000);
      if (frames.size() >= 1) begin
         check_frame("three", frames[0], 2'b10, PreLen + 24, line_model(3, 64'h00FF3C), 1, 0, 0);
         check_val("three_nacc", 64'(frames[0].nacc), 64'd3);
      end

      // Underrun: second byte withheld past bit 7 of the first
      frames.delete();
      b1 = 8'($urandom);
      s0_q.push_back('{d: b1, last: 1'b0, dly: 0});
      s0_q.push_back('{d: 8'($urandom), last: 1'b0, dly: 400});
      s0_q.push_back('{d: 8'($urandom), last: 1'b1, dly: 0});
      wait_frames(1, 3000);
      if (frames.size() >= 1) begin
         f = frames[0];
         check_frame("underrun", f, 2'b01, PreLen + 8, line_model(1, 64'(b1)), 0, 1, 0);
         check_val("underrun_valid_drop", 64'(f.vfall), 64'(f.und_cyc));
         check_val("underrun_nacc", 64'(f.nacc), 64'd3);
         check_val("underrun_gap_len", 64'(f.bfall - f.vfall) >= 64'(Ifg), 64'd1);
      end

      // Encoder stalls after 3 preamble bits: 64 tready-less cycles, then the error pulse
      frames.delete();
      stall_after = 3;
      build_frame(0, 2, 0, p);
      wait_frames(1, 3000);
      stall_after = -1;
      if (frames.size() >= 1) begin
         f = frames[0];
         check_frame("stall", f, 2'b01, 3, line_model(0, 64'd0) >> (PreLen - 3), 0, 0, 1);
         check_val("stall_tmo_delay", 64'(f.tmo_cyc - f.last_rdy), 64'(Tmo + 1));
         check_val("stall_valid_drop", 64'(f.vfall), 64'(f.tmo_cyc));
         check_val("stall_nacc", 64'(f.nacc), 64'd2);
      end

      // Reset in the middle of DATA, then a clean s1 frame
      frames.delete();
      build_frame(0, 3, 0, p);
      n = 0;
      while (!bus.busy && n < 100) begin
         @(posedge clk);
         n++;
      end
      repeat (200) @(posedge clk);
      check_val("mid_in_data", 64'({bus.busy, bus.enc_bit_valid}), 64'b11);
      apply_reset();
      n = int'($urandom_range(1, 2));
      build_frame(1, n, 2, p);
      wait_frames(1, 3000);
      if (frames.size() >= 1)
         check_frame("after_reset", frames[0], 2'b10, PreLen + 8 * n, line_model(n, p), 1, 0, 0);

      check_val("handshake_expired", 64'(hs_expired), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/miller_tx_scheduler.md
Name: miller_tx_scheduler

Overview:
- Frame-level scheduler in front of the Miller line encoder (32 MHz clk, 2 Mbit/s line, 16 clk/bit).
- Arbitrates between two byte-stream requesters, round-robin per whole frame.
- Prepends a fixed preamble, serializes bytes MSB-first and paces bits on the encoder's one-cycle tready pulse.
- Enforces an inter-frame gap; recovers from source underrun and encoder stall.

Parameters:
- PREAMBLE_LEN, 8, preamble length in bits (1..16).
- PREAMBLE, 16'h00AA, preamble pattern; bits [PREAMBLE_LEN-1:0] are sent MSB-first.
- IFG_CYCLES, 64, idle clk cycles between frames (4 bit periods).
- TIMEOUT_CYCLES, 64, max clk cycles without enc_bit_tready while a bit is presented.

Ports:
- clk  in  1  system clock, 32 MHz.
- rst_n  in  1  asynchronous active-low reset.
- s0_tdata  in  8  requester 0 byte.
- s0_tvalid  in  1  requester 0 byte valid.
- s0_tlast  in  1  requester 0 last byte of frame.
- s0_tready  out  1  requester 0 byte accepted when high with s0_tvalid.
- s1_tdata / s1_tvalid / s1_tlast / s1_tready: same as above, requester 1.
- enc_bit  out  1  bit to encoder.
- enc_bit_valid  out  1  encoder enable; high for the whole frame.
- enc_bit_tready  in  1  one-cycle pulse from encoder: current bit taken, present next.
- grant  out  2  one-hot owner of current frame; 0 when idle.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse at normal frame end.
- err_underrun  out  1  one-cycle pulse when the source has no byte ready in time.
- err_timeout  out  1  one-cycle pulse when the encoder stalls.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; RR pointer favours s0 next; buffers cleared. Mid-frame reset aborts immediately; enc_bit_valid drops with rst_n.
- States: IDLE, PRE, DATA, FLUSH, GAP.
- IDLE: if any sX_tvalid, register grant. If both are valid, grant the requester not served last; after reset, s0 wins. Go to PRE next cycle.
- Byte buffer: 1-byte prefetch register per active frame. sX_tready = granted & buffer empty & tlast not yet accepted & state in {PRE, DATA}. Accept on tvalid & tready. Latch tlast alongside the byte.
- PRE: enc_bit_valid=1, enc_bit = preamble bit idx (MSB-first). On each enc_bit_tready, idx++. When the last preamble bit's tready arrives:
  - buffer full: load shift register from buffer, go to DATA.
  - buffer empty: underrun.
- DATA: enc_bit = shift[7]. On each tready, shift left and increment the bit counter. On tready of bit 7:
  - byte was tlast: go to GAP, drop enc_bit_valid next cycle, pulse frame_done.
  - buffer full: reload and continue.
  - buffer empty: underrun.
- enc_bit changes only in the cycle after a tready pulse; it is stable otherwise.
- Underrun: pulse err_underrun, drop enc_bit_valid. If tlast was already accepted go to GAP, else go to FLUSH.
- Timeout: in PRE/DATA, a counter resets on each tready. Reaching TIMEOUT_CYCLES pulses err_timeout, drops enc_bit_valid, then FLUSH (or GAP if tlast already accepted).
- FLUSH: sX_tready=1 for the granted source; discard bytes until tvalid & tlast, then go to GAP. No timeout in FLUSH.
- GAP: grant held, enc_bit_valid=0, count IFG_CYCLES clk cycles, then IDLE. Update the RR pointer to the served requester; grant clears in IDLE.
- Requests arriving during PRE/DATA/FLUSH/GAP are held off (tready=0) until the next arbitration.
- A simultaneous tready pulse and timeout terminal count: tready wins.
- Frame bit count on the line = PREAMBLE_LEN + 8*N.

Test Plan:
- Single frame s0 {0xA5, tlast}, encoder model with tready every 16 clk -> line bits 10101010 10100101; grant=01; frame_done exactly once; enc_bit_valid low the cycle after the 16th tready; then 64 idle cycles.
- s0 and s1 both valid in IDLE after reset -> s0 frame first, then s1, then s0 again with both continuously requesting (strict alternation); grant never changes mid-frame.
- s1 three-byte frame {0x00, 0xFF, 0x3C} with each byte presented only after tready -> 32 continuous bits, no underrun; s1_tready high exactly 3 cycles.
- s0 withholds byte 2 past bit 7 of byte 1 -> err_underrun pulse, enc_bit_valid=0; remaining bytes through tlast are accepted and discarded; GAP then IDLE.
- Encoder tready stuck low after 3 preamble bits -> err_timeout 64 cycles after the last tready, valid drops, FLUSH/GAP, no frame_done.
- Assert rst_n=0 mid-DATA -> all outputs 0 asynchronously; after release with s1 valid, s0 idle -> s1 granted, starts cleanly with full preamble.
